// File: rtl/tob_pkg.sv
// tob_pkg: shared screen constants and renderer state encoding
package tob_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_CLEAR, S_DONE} state_t;
endpackage

// File: rtl/pixel_scanner.sv
// pixel_scanner: row-major 2-D offset counter, block-sized or full-screen
module pixel_scanner
    import tob_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    input  logic       full,
    output logic [7:0] cx,
    output logic [6:0] cy,
    output logic       last
);
    logic [7:0] wm;
    logic [6:0] hm;
    assign wm   = full ? 8'(SCREEN_W - 1) : 8'(W - 1);
    assign hm   = full ? 7'(SCREEN_H - 1) : 7'(H - 1);
    assign last = cx == wm && cy == hm;
    // Wrapping at the end leaves the counter at zero, ready for the next phase
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            cx <= '0;
            cy <= '0;
        end else if (step) begin
            cx <= cx == wm ? 8'd0 : cx + 8'd1;
            if (cx == wm)
                cy <= cy == hm ? 7'd0 : cy + 7'd1;
        end
    end
endmodule

// File: rtl/block_renderer.sv
// block_renderer: erases the previous block, draws the new one, or clears the screen
module block_renderer
    import tob_pkg::*;
#(
    parameter int                  BLOCK_W   = 16,
    parameter int                  BLOCK_H   = 4,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req,
    input  logic                clear_req,
    input  logic [7:0]          x_pos,
    input  logic [6:0]          y_pos,
    input  logic [COLOUR_W-1:0] colour,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);
    state_t state;
    logic [7:0] nx, lx, bx, cx;
    logic [6:0] ny, ly, by, cy;
    logic [COLOUR_W-1:0] nc;
    logic valid, last, start;
    logic [8:0] sx;
    logic [7:0] sy;
    assign start = state == S_IDLE && (req || clear_req);
    pixel_scanner #(.W(BLOCK_W), .H(BLOCK_H)) u_scan (
        .clk(clk), .resetn(resetn), .start(start), .step(busy),
        .full(state == S_CLEAR), .cx(cx), .cy(cy), .last(last)
    );
    always_comb begin
        bx = state == S_ERASE ? lx : (state == S_CLEAR ? 8'd0 : nx);
        by = state == S_ERASE ? ly : (state == S_CLEAR ? 7'd0 : ny);
        sx = {1'b0, bx} + {1'b0, cx};
        sy = {1'b0, by} + {1'b0, cy};
    end
    // Off-screen pixels still take their cycle but are never written
    assign vga_plot   = busy && sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H);
    assign vga_x      = sx[7:0];
    assign vga_y      = sy[6:0];
    assign vga_colour = (state == S_ERASE || state == S_CLEAR) ? BG_COLOUR : nc;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            nx    <= '0;
            ny    <= '0;
            nc    <= '0;
            lx    <= '0;
            ly    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (clear_req) begin
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                    end else if (req) begin
                        nx    <= x_pos;
                        ny    <= y_pos;
                        nc    <= colour;
                        state <= valid ? S_ERASE : S_DRAW;
                        busy  <= 1'b1;
                    end
                S_ERASE:
                    if (last) state <= S_DRAW;
                S_DRAW:
                    if (last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        lx    <= nx;
                        ly    <= ny;
                        valid <= 1'b1;
                    end
                S_CLEAR:
                    if (last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_renderer.sv
// tb_block_renderer: table-driven check of block_renderer against a per-pixel reference model
module tb_block_renderer;
    logic       clk = 0, resetn = 0, req = 0, clear_req = 0;
    logic [7:0] x_pos = 0;
    logic [6:0] y_pos = 0;
    logic [2:0] colour = 0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    block_renderer dut (
        .clk(clk), .resetn(resetn), .req(req), .clear_req(clear_req),
        .x_pos(x_pos), .y_pos(y_pos), .colour(colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         clr;
        bit         rq;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         exp_done;
        int         exp_plots;
        int         spur1;
        int         spur2;
        int         rst_at;
    } vec_t;

    int tests = 0, fails = 0;
    bit m_valid = 0;
    int m_lx = 0, m_ly = 0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        int n_er, n_dr, total, bad, plots, done_at, p, bx, by, w, idx, ex, ey, ec;
        bit ep;
        string first_bad;
        n_dr = v.clr ? 19200 : 64;
        n_er = (!v.clr && m_valid) ? 64 : 0;
        total = n_er + n_dr;
        bad = 0; plots = 0; done_at = -1; first_bad = "";
        @(negedge clk);
        clear_req = v.clr; req = v.rq; x_pos = v.x; y_pos = v.y; colour = v.c;
        for (int t = 1; t <= v.exp_done + 5 && done_at < 0; t++) begin
            @(negedge clk);
            clear_req = 0;
            if (done === 1'b1) begin
                done_at = t;
                check({name, "_done_idle"}, {busy, vga_plot}, 0);
            end else if (t <= total) begin
                p = t - 1;
                if (p < n_er) begin
                    bx = m_lx; by = m_ly; ec = 0; idx = p; w = 16;
                end else if (v.clr) begin
                    bx = 0; by = 0; ec = 0; idx = p; w = 160;
                end else begin
                    bx = v.x; by = v.y; ec = v.c; idx = p - n_er; w = 16;
                end
                ex = bx + idx % w;
                ey = by + idx / w;
                ep = ex < 160 && ey < 120;
                if (vga_plot !== ep || busy !== 1'b1 ||
                    (ep && (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'(ec)))) begin
                    if (bad == 0)
                        first_bad = $sformatf("t=%0d plot=%b (%0d,%0d) c=%0d busy=%b, want plot=%b (%0d,%0d) c=%0d",
                                              t, vga_plot, vga_x, vga_y, vga_colour, busy, ep, ex, ey, ec);
                    bad++;
                end
            end
            if (vga_plot === 1'b1) plots++;
            if (t == v.rst_at) begin
                resetn = 0; req = 0;
                @(negedge clk);
                check({name, "_reset_state"}, {busy, vga_plot, done}, 0);
                resetn = 1;
                m_valid = 0;
                return;
            end
            req = (t == v.spur1 || t == v.spur2);
            x_pos = 100; y_pos = 5; colour = 7;
        end
        req = 0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_stream: %0d bad cycles, first %s", name, bad, first_bad);
        end
        check({name, "_done_cycle"}, done_at, v.exp_done);
        check({name, "_plots"}, plots, v.exp_plots);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({name, "_idle_after"}, {busy, done, vga_plot}, 0);
        end
        if (v.clr) m_valid = 0;
        else if (v.rq) begin
            m_valid = 1; m_lx = v.x; m_ly = v.y;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'd40,  7'd100, 3'd4, 65,    64,    0,  0,  0};
        vecs[1] = '{1'b0, 1'b1, 8'd44,  7'd96,  3'd2, 129,   128,   0,  0,  0};
        vecs[2] = '{1'b1, 1'b1, 8'd10,  7'd10,  3'd5, 19201, 19200, 0,  0,  0};
        vecs[3] = '{1'b0, 1'b1, 8'd150, 7'd118, 3'd5, 65,    20,    0,  0,  0};
        vecs[4] = '{1'b0, 1'b1, 8'd0,   7'd0,   3'd7, 129,   84,    0,  0,  0};
        vecs[5] = '{1'b0, 1'b1, 8'd159, 7'd119, 3'd6, 129,   65,    0,  0,  0};
        vecs[6] = '{1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 19201, 19200, 0,  0,  0};
        vecs[7] = '{1'b0, 1'b1, 8'd30,  7'd40,  3'd6, 65,    64,    0,  0,  20};
        vecs[8] = '{1'b0, 1'b1, 8'd20,  7'd20,  3'd1, 65,    64,    10, 30, 0};
        vecs[9] = '{1'b0, 1'b1, 8'd60,  7'd60,  3'd2, 129,   128,   0,  0,  0};
        repeat (3) @(negedge clk);
        check("reset_flags", {busy, done, vga_plot}, 0);
        check("reset_vga_x", vga_x, 0);
        check("reset_vga_y", vga_y, 0);
        check("reset_vga_colour", vga_colour, 0);
        resetn = 1;
        for (int i = 0; i < 10; i++)
            do_op(vecs[i], $sformatf("op%0d", i));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
